// File: rtl/sklansky_sub16_pipe_if.sv
// Handshake and data bundle for the 16-bit pipelined Sklansky subtractor.
interface sklansky_sub16_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  // Producer/consumer side: drives operands and result back-pressure.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero
  );
endinterface

// File: rtl/sklansky_sub16_pipe.sv
// 16-bit subtractor a - b - bin built on a 4-level Sklansky prefix tree,
// split over two pipeline stages with valid/ready flow control.
// Stage 1: bit g/p and prefix levels 1-2 (span 4).
// Stage 2: prefix levels 3-4 (span 16), sum XOR and flags, registered outputs.
module sklansky_sub16_pipe (
  input  logic              clk,
  input  logic              rst_n,
  sklansky_sub16_pipe_if.slave bus
);

  // ---------------- flow control ----------------
  logic r_v1, r_v2;
  logic w_s2_load, w_s1_moves, w_in_ready, w_in_fire;

  assign w_s2_load  = !r_v2 || bus.out_ready;
  assign w_s1_moves = r_v1 && w_s2_load;
  assign w_in_ready = !r_v1 || w_s1_moves;
  assign w_in_fire  = bus.in_valid && w_in_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v2;

  // ---------------- stage 1 combinational ----------------
  // Subtraction as a + ~b + ~bin.
  logic [15:0] w_g, w_p, w_g1, w_p1, w_g2, w_p2;

  // Bit generate/propagate, then span-2 and span-4 Sklansky levels.
  always_comb begin
    w_g  = bus.a & ~bus.b;
    w_p  = bus.a ^ ~bus.b;
    w_g1 = w_g;
    w_p1 = w_p;
    for (int i = 0; i < 16; i++) begin
      if ((i & 1) != 0) begin
        w_g1[i] = w_g[i] | (w_p[i] & w_g[(i & ~1)]);
        w_p1[i] = w_p[i] & w_p[(i & ~1)];
      end
    end
    w_g2 = w_g1;
    w_p2 = w_p1;
    for (int i = 0; i < 16; i++) begin
      if ((i & 2) != 0) begin
        w_g2[i] = w_g1[i] | (w_p1[i] & w_g1[(i & ~3) | 1]);
        w_p2[i] = w_p1[i] & w_p1[(i & ~3) | 1];
      end
    end
  end

  // ---------------- stage 1 register ----------------
  logic [15:0] r_g2, r_p2, r_p;
  logic        r_cin;

  // Stage-1 valid flag; clears asynchronously to drop in-flight beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_v1 <= 1'b0;
    else if (w_in_ready) r_v1 <= bus.in_valid;
  end

  // Stage-1 data: group G/P over span 4, bit propagate and carry-in.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_g2  <= w_g2;
      r_p2  <= w_p2;
      r_p   <= w_p;
      r_cin <= ~bus.bin;
    end
  end

  // ---------------- stage 2 combinational ----------------
  logic [15:0] w_g3, w_p3, w_g4, w_p4, w_diff;
  logic [16:0] w_c;
  logic        w_bout, w_ovf, w_zero;

  // Span-8 and span-16 levels, then carries with the carry-in folded in.
  always_comb begin
    w_g3 = r_g2;
    w_p3 = r_p2;
    for (int i = 0; i < 16; i++) begin
      if ((i & 4) != 0) begin
        w_g3[i] = r_g2[i] | (r_p2[i] & r_g2[(i & ~7) | 3]);
        w_p3[i] = r_p2[i] & r_p2[(i & ~7) | 3];
      end
    end
    w_g4 = w_g3;
    w_p4 = w_p3;
    for (int i = 0; i < 16; i++) begin
      if ((i & 8) != 0) begin
        w_g4[i] = w_g3[i] | (w_p3[i] & w_g3[7]);
        w_p4[i] = w_p3[i] & w_p3[7];
      end
    end
    w_c[0] = r_cin;
    for (int i = 0; i < 16; i++) w_c[i+1] = w_g4[i] | (w_p4[i] & r_cin);
  end

  assign w_diff = r_p ^ w_c[15:0];
  assign w_bout = ~w_c[16];
  // Carry into the MSB differing from carry out of it is exactly the
  // "operand signs differ and result sign differs from a" condition.
  assign w_ovf  = w_c[16] ^ w_c[15];
  assign w_zero = (w_diff == 16'h0000);

  // ---------------- stage 2 register ----------------
  logic [15:0] r_diff;
  logic        r_bout, r_ovf, r_zero;

  // Stage-2 valid and result registers; results hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2   <= 1'b0;
      r_diff <= 16'h0000;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_s2_load) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_diff <= w_diff;
        r_bout <= w_bout;
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;

endmodule
